// File: rtl/input_conditioner.sv
// N-channel switch conditioner: synchroniser, debouncer, clean level and press/release pulses.
// Optional auto-repeat of press while held is built when AUTO_REPEAT_EN is defined.
module input_conditioner #(
  parameter int N               = 1,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int REPEAT_DELAY    = 32,
  parameter int REPEAT_PERIOD   = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [N-1:0] in,
  output logic [N-1:0] level,
  output logic [N-1:0] press,
  output logic [N-1:0] release_pulse,
  output logic         press_any
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [N-1:0] press_nxt;
  logic [N-1:0] rel_nxt;

  for (genvar i = 0; i < N; i++) begin : g_ch
    logic [SYNC_STAGES-1:0] chain;
    logic [CW-1:0]          cnt;
    logic                   lvl_q;
    logic                   s;
    logic                   accept;

    assign s      = chain[SYNC_STAGES-1];
    assign accept = (s != lvl_q) && (cnt == CNT_LAST);

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        chain <= '0;
      end else begin
        chain <= {chain[SYNC_STAGES-2:0], in[i]};
      end
    end

    // Any sample agreeing with the current level restarts the count.
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        cnt   <= '0;
        lvl_q <= 1'b0;
      end else if (s == lvl_q) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        cnt   <= '0;
        lvl_q <= s;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end

    assign level[i]   = lvl_q;
    assign rel_nxt[i] = accept && !s;

`ifdef AUTO_REPEAT_EN
    localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int RW   = $clog2(RMAX + 1);
    localparam logic [RW-1:0] DELAY_LAST  = RW'(REPEAT_DELAY - 1);
    localparam logic [RW-1:0] PERIOD_LAST = RW'(REPEAT_PERIOD - 1);

    logic [RW-1:0] rep_cnt;
    logic          rep_phase;
    logic          rep_fire;

    // A level transition on this edge always wins over a repeat.
    assign rep_fire = lvl_q && !accept &&
                      (rep_phase ? (rep_cnt == PERIOD_LAST) : (rep_cnt == DELAY_LAST));

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        rep_cnt   <= '0;
        rep_phase <= 1'b0;
      end else if (!lvl_q || accept) begin
        rep_cnt   <= '0;
        rep_phase <= 1'b0;
      end else if (rep_fire) begin
        rep_cnt   <= '0;
        rep_phase <= 1'b1;
      end else begin
        rep_cnt <= rep_cnt + 1'b1;
      end
    end

    assign press_nxt[i] = (accept && s) || rep_fire;
`else
    assign press_nxt[i] = accept && s;
`endif
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      press         <= '0;
      release_pulse <= '0;
      press_any     <= 1'b0;
    end else begin
      press         <= press_nxt;
      release_pulse <= rel_nxt;
      press_any     <= |press_nxt;
    end
  end

endmodule

// File: tb/tb_input_conditioner.sv
// Scoreboard bench for input_conditioner: three instances (N=4/DB=4, N=1/DB=16, N=1/DB=1).
// Expected pulse events are queued at stimulus time; a negedge monitor pops one per observed pulse.
module tb_input_conditioner;

  localparam int RW = 31;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;

  logic [3:0] in_a = '0, level_a, press_a, rel_a;
  logic       any_a;
  logic [0:0] in_b = '0, level_b, press_b, rel_b;
  logic       any_b;
  logic [0:0] in_c = '0, level_c, press_c, rel_c;
  logic       any_c;

  logic [RW-1:0] exp_q[$];
  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  input_conditioner #(.N(4), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(4)) dut_a (
    .clk(clk), .reset(rst), .in(in_a), .level(level_a), .press(press_a),
    .release_pulse(rel_a), .press_any(any_a));

  input_conditioner #(.N(1), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(16)) dut_b (
    .clk(clk), .reset(rst), .in(in_b), .level(level_b), .press(press_b),
    .release_pulse(rel_b), .press_any(any_b));

  input_conditioner #(.N(1), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(1)) dut_c (
    .clk(clk), .reset(rst), .in(in_c), .level(level_c), .press(press_c),
    .release_pulse(rel_c), .press_any(any_c));

  // Record layout: {inst[1:0], cycle[15:0], press[3:0], release[3:0], level[3:0], press_any}
  function automatic logic [RW-1:0] rec(input int inst, input int at, input logic [3:0] p,
                                        input logic [3:0] r, input logic [3:0] l, input logic any);
    rec = {inst[1:0], at[15:0], p, r, l, any};
  endfunction

  task automatic exp_ev(input int inst, input int at, input logic [3:0] p,
                        input logic [3:0] r, input logic [3:0] l);
    exp_q.push_back(rec(inst, at, p, r, l, |p));
  endtask

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic compare(input logic [RW-1:0] act);
    logic [RW-1:0] e;
    checks++;
    if (exp_q.size() == 0) begin
      failures++;
      $display("FAIL unexpected_pulse: inst=%0d cyc=%0d press=%b rel=%b level=%b any=%b",
               act[30:29], act[28:13], act[12:9], act[8:5], act[4:1], act[0]);
    end else begin
      e = exp_q.pop_front();
      if (act !== e) begin
        failures++;
        $display("FAIL pulse_event: got inst=%0d cyc=%0d p=%b r=%b l=%b any=%b, expected inst=%0d cyc=%0d p=%b r=%b l=%b any=%b",
                 act[30:29], act[28:13], act[12:9], act[8:5], act[4:1], act[0],
                 e[30:29], e[28:13], e[12:9], e[8:5], e[4:1], e[0]);
      end
    end
  endtask

  always @(negedge clk) begin
    if (|press_a || |rel_a) compare(rec(0, cyc, press_a, rel_a, level_a, any_a));
    if (press_b[0] || rel_b[0]) compare(rec(1, cyc, {3'b0, press_b}, {3'b0, rel_b}, {3'b0, level_b}, any_b));
    if (press_c[0] || rel_c[0]) compare(rec(2, cyc, {3'b0, press_c}, {3'b0, rel_c}, {3'b0, level_c}, any_c));
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, time=%0t", $time);
    $fatal(1);
  end

  initial begin
    int c, r, t;
    int bnc[7] = '{1, 1, 0, 1, 1, 1, 1};

    // Power-on reset.
    #1;
    chk("reset_level_a", int'(level_a), 0);
    chk("reset_press_a", int'(press_a), 0);
    chk("reset_any_a",   int'(any_a),   0);
    tick(3);
    rst = 1'b0;
    tick(2);

    // Single channel rise and fall, DB=4: change on the 6th sampling edge.
    c = cyc + 1;
    in_a = 4'b0001;
    exp_ev(0, c + 5, 4'b0001, 4'b0000, 4'b0001);
    tick(10);
    c = cyc + 1;
    in_a = 4'b0000;
    exp_ev(0, c + 5, 4'b0000, 4'b0001, 4'b0000);
    tick(10);

    // A 3-cycle glitch must be rejected.
    in_a[0] = 1'b1;
    tick(3);
    in_a[0] = 1'b0;
    tick(10);
    chk("glitch_level", int'(level_a), 0);

    // Bounce then hold high for 1000 cycles; rise counts from the first 1 after the last 0.
    c = 0;
    for (int k = 0; k < 7; k++) begin
      if (k == 3) begin
        c = cyc + 1;
        r = c + 1000;
        exp_ev(0, c + 5, 4'b0001, 4'b0000, 4'b0001);
`ifdef AUTO_REPEAT_EN
        t = c + 5 + 32;
        while (t < r + 5) begin
          exp_ev(0, t, 4'b0001, 4'b0000, 4'b0001);
          t += 8;
        end
`endif
        exp_ev(0, r + 5, 4'b0000, 4'b0001, 4'b0000);
      end
      in_a[0] = bnc[k][0];
      tick(1);
    end
    while (cyc + 1 < r) tick(1);
    chk("hold_level", int'(level_a), 1);
    in_a[0] = 1'b0;
    tick(12);

    // Simultaneous presses across channels, then one late channel, then a joint release.
    c = cyc + 1;
    in_a = 4'b1011;
    exp_ev(0, c + 5, 4'b1011, 4'b0000, 4'b1011);
    tick(8);
    c = cyc + 1;
    in_a = 4'b1111;
    exp_ev(0, c + 5, 4'b0100, 4'b0000, 4'b1111);
    tick(8);
    c = cyc + 1;
    in_a = 4'b0000;
    exp_ev(0, c + 5, 4'b0000, 4'b1111, 4'b0000);
    tick(12);

    // DB=1: square wave of period 4 gives alternating pulses every 2 cycles.
    for (int k = 0; k < 4; k++) begin
      c = cyc + 1;
      in_c = 1'b1;
      exp_ev(2, c + 2, 4'b0001, 4'b0000, 4'b0001);
      tick(2);
      c = cyc + 1;
      in_c = 1'b0;
      exp_ev(2, c + 2, 4'b0000, 4'b0001, 4'b0000);
      tick(2);
    end
    tick(6);

    // DB=16: press after 18 edges, then asynchronous reset mid-cycle with level high.
    c = cyc + 1;
    in_b = 1'b1;
    exp_ev(1, c + 17, 4'b0001, 4'b0000, 4'b0001);
    tick(25);
    chk("b_level_before_reset", int'(level_b), 1);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("async_reset_level_b", int'(level_b), 0);
    chk("async_reset_press_b", int'(press_b), 0);
    chk("async_reset_rel_b",   int'(rel_b),   0);
    chk("async_reset_any_b",   int'(any_b),   0);
    tick(3);
    c = cyc + 1;
    rst = 1'b0;
    exp_ev(1, c + 17, 4'b0001, 4'b0000, 4'b0001);
    tick(20);
    c = cyc + 1;
    in_b = 1'b0;
    exp_ev(1, c + 17, 4'b0000, 4'b0001, 4'b0000);
    tick(24);

    chk("queue_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
